// File: rtl/mvm_seq_engine_pkg.sv
// Shared state encoding, header bit positions and sizing helpers for the
// time-multiplexed matrix-vector multiply engine.
package mvm_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD_K,
    LOAD_X,
    COMPUTE,
    SEND
  } state_t;

  localparam int HDR_LOAD_K = 0;
  localparam int HDR_SIGNED = 1;

  function automatic int acc_width(input int w_k, input int w_x, input int c);
    return w_k + w_x + $clog2(c);
  endfunction

  function automatic int num_bytes(input int w_y, input int bpw);
    return (w_y + bpw - 1) / bpw;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_seq_engine_mac.sv
// Single multiply-accumulate lane: extends K and x, accumulates one product per
// enabled cycle and fits the final row sum to W_Y (clamped when MVM_SATURATE_EN).
module mvm_mac
  import mvm_pkg::*;
#(
  parameter int W_K = 4,
  parameter int W_X = 4,
  parameter int W_Y = 10,
  parameter int AW  = 10
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           first,
  input  logic           is_signed,
  input  logic [W_K-1:0] k,
  input  logic [W_X-1:0] x,
  output logic [W_Y-1:0] y
);

  logic [AW-1:0] k_ext;
  logic [AW-1:0] x_ext;
  logic [AW-1:0] prod;
  logic [AW-1:0] sum;
  logic [AW-1:0] acc_reg;

  // Low AW bits of the product are identical for signed and unsigned operands.
  assign k_ext = {{(AW-W_K){is_signed & k[W_K-1]}}, k};
  assign x_ext = {{(AW-W_X){is_signed & x[W_X-1]}}, x};
  assign prod  = k_ext * x_ext;
  assign sum   = (first ? '0 : acc_reg) + prod;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

  generate
    if (W_Y > AW) begin : g_extend
      assign y = {{(W_Y-AW){is_signed & sum[AW-1]}}, sum};
    end else if (W_Y == AW) begin : g_exact
      assign y = sum;
    end else begin : g_narrow
`ifdef MVM_SATURATE_EN
      logic ovf_u;
      logic ovf_s;
      assign ovf_u = |sum[AW-1:W_Y];
      assign ovf_s = (sum[AW-1:W_Y-1] != '0) && (sum[AW-1:W_Y-1] != '1);
      always_comb begin
        y = sum[W_Y-1:0];
        if (is_signed) begin
          if (ovf_s) y = sum[AW-1] ? {1'b1, {(W_Y-1){1'b0}}} : {1'b0, {(W_Y-1){1'b1}}};
        end else if (ovf_u) begin
          y = '1;
        end
      end
`else
      logic unused_hi;
      assign unused_hi = ^sum[AW-1:W_Y];
      assign y = sum[W_Y-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/mvm_seq_engine.sv
// Byte-stream y = K*x engine with per-frame header (LOAD_K, SIGNED) and one MAC
// per cycle. Optional MVM_SATURATE_EN clamps results instead of wrapping.
module mvm_seq_engine
  import mvm_pkg::*;
#(
  parameter int R             = 4,
  parameter int C             = 4,
  parameter int W_K           = 4,
  parameter int W_X           = 4,
  parameter int W_Y           = acc_width(W_K, W_X, C),
  parameter int BITS_PER_WORD = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [BITS_PER_WORD-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = acc_width(W_K, W_X, C);
  localparam int NB = num_bytes(W_Y, BITS_PER_WORD);
  localparam int PW = NB * BITS_PER_WORD;
  localparam int RW = idx_width(R);
  localparam int CW = idx_width(C);
  localparam int BW = idx_width(NB);

  state_t        state_reg, state_next;
  logic [RW-1:0] row_reg, row_next, row_inc;
  logic [CW-1:0] col_reg, col_next, col_inc;
  logic [BW-1:0] byte_reg, byte_next, byte_inc;
  logic          signed_reg, signed_next;
  logic          done_reg, done_next;
  logic          row_last, col_last, byte_last;
  logic          s_fire, m_fire, k_we, x_we, mac_en;
  logic          unused_sdata;
  logic [W_Y-1:0] mac_y;

  logic [W_K-1:0] k_mem [R][C];
  logic [W_X-1:0] x_mem [C];
  logic [W_Y-1:0] y_mem [R];
  logic [PW-1:0]  y_pad [R];

  assign s_ready = (state_reg == HDR) || (state_reg == LOAD_K) || (state_reg == LOAD_X);
  assign m_valid = (state_reg == SEND);
  assign busy    = (state_reg != HDR);
  assign done    = done_reg;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  assign unused_sdata = ^s_data;

  assign row_last  = (row_reg == RW'(R - 1));
  assign col_last  = (col_reg == CW'(C - 1));
  assign byte_last = (byte_reg == BW'(NB - 1));
  assign row_inc   = row_last ? '0 : row_reg + 1'b1;
  assign col_inc   = col_last ? '0 : col_reg + 1'b1;
  assign byte_inc  = byte_last ? '0 : byte_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    byte_next   = byte_reg;
    signed_next = signed_reg;
    done_next   = 1'b0;
    k_we        = 1'b0;
    x_we        = 1'b0;
    mac_en      = 1'b0;
    case (state_reg)
      HDR: if (s_fire) begin
        signed_next = s_data[HDR_SIGNED];
        row_next    = '0;
        col_next    = '0;
        state_next  = s_data[HDR_LOAD_K] ? LOAD_K : LOAD_X;
      end
      LOAD_K: if (s_fire) begin
        k_we     = 1'b1;
        col_next = col_inc;
        if (col_last) begin
          row_next = row_inc;
          if (row_last) state_next = LOAD_X;
        end
      end
      LOAD_X: if (s_fire) begin
        x_we     = 1'b1;
        col_next = col_inc;
        if (col_last) state_next = COMPUTE;
      end
      COMPUTE: begin
        mac_en   = 1'b1;
        col_next = col_inc;
        if (col_last) begin
          row_next = row_inc;
          if (row_last) begin
            state_next = SEND;
            byte_next  = '0;
          end
        end
      end
      SEND: if (m_fire) begin
        byte_next = byte_inc;
        if (byte_last) begin
          row_next = row_inc;
          if (row_last) begin
            state_next = HDR;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= HDR;
      row_reg    <= '0;
      col_reg    <= '0;
      byte_reg   <= '0;
      signed_reg <= 1'b0;
      done_reg   <= 1'b0;
      for (int r = 0; r < R; r++) begin
        y_mem[r] <= '0;
        for (int c = 0; c < C; c++) k_mem[r][c] <= '0;
      end
      for (int c = 0; c < C; c++) x_mem[c] <= '0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      byte_reg   <= byte_next;
      signed_reg <= signed_next;
      done_reg   <= done_next;
      if (k_we) k_mem[row_reg][col_reg] <= s_data[W_K-1:0];
      if (x_we) x_mem[col_reg] <= s_data[W_X-1:0];
      if (mac_en && col_last) y_mem[row_reg] <= mac_y;
    end
  end

  mvm_mac #(
    .W_K (W_K),
    .W_X (W_X),
    .W_Y (W_Y),
    .AW  (AW)
  ) u_mac (
    .clk       (clk),
    .rstn      (rstn),
    .en        (mac_en),
    .first     (col_reg == '0),
    .is_signed (signed_reg),
    .k         (k_mem[row_reg][col_reg]),
    .x         (x_mem[col_reg]),
    .y         (mac_y)
  );

  // Spare bits of the top output byte carry the sign in signed frames.
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_pad
      if (PW > W_Y) begin : g_ext
        assign y_pad[gi] = {{(PW-W_Y){signed_reg & y_mem[gi][W_Y-1]}}, y_mem[gi]};
      end else begin : g_fit
        assign y_pad[gi] = y_mem[gi];
      end
    end
  endgenerate

  assign m_data = m_valid ? y_pad[row_reg][byte_reg*BITS_PER_WORD +: BITS_PER_WORD] : '0;

endmodule

// File: tb/tb_mvm_seq_engine.sv
// Bench for mvm_seq_engine: directed frames plus random frames against an
// integer-arithmetic reference, with a second instance at W_Y=8.
module tb_mvm_seq_engine;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int W_K  = 4;
  localparam int W_X  = 4;
  localparam int W_Y  = 10;
  localparam int W_Y8 = 8;
  localparam int NB   = (W_Y + 7) / 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic       junk = 1'b0;
  logic       s_ready, m_valid, busy, done;
  logic [7:0] m_data;
  logic       s_valid8, s_ready8, m_valid8, busy8, done8;
  logic [7:0] m_data8;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int k_stim [R][C];
  int k_model [R][C];
  int x_stim [C];
  logic [7:0] exp_q [$];
  logic [7:0] exp8_q [$];
  logic [7:0] got8_q [$];
  logic [7:0] hdr_r;

  always #5 clk = ~clk;

  // Junk bytes are only aimed at the main instance while it refuses input.
  assign s_valid8 = s_valid & ~junk;

  mvm_seq_engine #(.R(R), .C(C), .W_K(W_K), .W_X(W_X), .W_Y(W_Y), .BITS_PER_WORD(8)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  mvm_seq_engine #(.R(R), .C(C), .W_K(W_K), .W_X(W_X), .W_Y(W_Y8), .BITS_PER_WORD(8)) dut8 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid8), .s_ready(s_ready8),
    .m_data(m_data8), .m_valid(m_valid8), .m_ready(1'b1), .busy(busy8), .done(done8)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (m_valid8) got8_q.push_back(m_data8);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sval(input int v, input int w, input bit sgn);
    int m;
    m = v & ((1 << w) - 1);
    if (sgn && m >= (1 << (w - 1))) return longint'(m - (1 << w));
    return longint'(m);
  endfunction

  function automatic longint fit(input longint full, input int wy, input bit sgn);
    longint m;
`ifdef MVM_SATURATE_EN
    longint lo, hi;
    lo = sgn ? -(64'sd1 <<< (wy - 1)) : 64'sd0;
    hi = sgn ? (64'sd1 <<< (wy - 1)) - 1 : (64'sd1 <<< wy) - 1;
    m = (full < lo) ? lo : (full > hi) ? hi : full;
`else
    m = full & ((64'sd1 <<< wy) - 1);
    if (sgn && m >= (64'sd1 <<< (wy - 1))) m = m - (64'sd1 <<< wy);
`endif
    return m;
  endfunction

  task automatic build_exp(input bit sgn);
    longint full, y;
    exp_q.delete();
    exp8_q.delete();
    for (int r = 0; r < R; r++) begin
      full = 0;
      for (int c = 0; c < C; c++) full += sval(k_model[r][c], W_K, sgn) * sval(x_stim[c], W_X, sgn);
      y = fit(full, W_Y, sgn);
      for (int b = 0; b < NB; b++) exp_q.push_back(8'((y >> (8 * b)) & 255));
      y = fit(full, W_Y8, sgn);
      exp8_q.push_back(8'(y & 255));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready wait", s_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst s_ready", s_ready, 1'b1);
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_data", m_data, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] hdr, input bit stall);
    int lat, n, d0;
    if (hdr[0]) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) k_model[r][c] = k_stim[r][c];
    end
    build_exp(hdr[1]);
    got8_q.delete();
    d0 = done_cnt;
    send_byte(hdr);
    if (hdr[0]) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) send_byte(8'(k_stim[r][c]) | {4'($urandom), 4'h0});
    end
    for (int c = 0; c < C; c++) send_byte(8'(x_stim[c]) | {4'($urandom), 4'h0});
    if (stall) begin
      junk    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (stall) check("compute s_ready", s_ready, 1'b0);
    end while (!m_valid && lat < 200);
    check("latency", lat, R * C + 1);
    for (int i = 0; i < R * NB; i++) begin
      if (i > 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_valid && n < 100);
      end
      check("m_valid", m_valid, 1'b1);
      check($sformatf("y[%0d] byte %0d", i / NB, i % NB), m_data, exp_q[i]);
      if (stall) check("send s_ready", s_ready, 1'b0);
      if (stall && i == 0) begin
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall m_data", m_data, exp_q[0]);
          check("stall m_valid", m_valid, 1'b1);
        end
        m_ready = 1'b1;
      end
    end
    @(negedge clk);
    junk    = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("done pulses", done_cnt - d0, 1);
    check("done low after", done, 1'b0);
    check("busy idle", busy, 1'b0);
    check("w8 count", got8_q.size(), R);
    for (int i = 0; i < R; i++)
      check($sformatf("w8 y[%0d]", i), (i < got8_q.size()) ? got8_q[i] : 8'hxx, exp8_q[i]);
  endtask

  initial begin
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) k_model[r][c] = 0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rstn = 1'b1;

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) k_stim[r][c] = (r == c) ? 1 : 0;
    x_stim = '{1, 2, 3, 4};
    run_frame(8'h01, 1'b0);

    x_stim = '{5, 6, 7, 8};
    run_frame(8'h00, 1'b0);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) k_stim[r][c] = 15;
    x_stim = '{1, 1, 1, 1};
    run_frame(8'h03, 1'b0);

    x_stim = '{15, 15, 15, 15};
    run_frame(8'h01, 1'b0);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) k_stim[r][c] = (r == c) ? 1 : 0;
    x_stim = '{1, 2, 3, 4};
    run_frame(8'h01, 1'b1);

    send_byte(8'h01);
    repeat (5) send_byte(8'($urandom));
    #2 rstn = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) k_model[r][c] = 0;
    #1 check_reset_state();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    x_stim = '{9, 9, 9, 9};
    run_frame(8'h00, 1'b0);

    repeat (8) begin
      hdr_r = 8'($urandom);
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) k_stim[r][c] = int'($urandom_range(0, 15));
      for (int c = 0; c < C; c++) x_stim[c] = int'($urandom_range(0, 15));
      run_frame(hdr_r, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
